// File: rtl/sa_result_pool.sv
// sa_result_pool: captures four serial conv results into a 2x2 frame with running max-pool and valid/ready drain
module sa_result_pool #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              sa_en_result,
  input  logic [DATA_W-1:0] sa_result,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] r_1_1,
  output logic [DATA_W-1:0] r_1_2,
  output logic [DATA_W-1:0] r_2_1,
  output logic [DATA_W-1:0] r_2_2,
  output logic [DATA_W-1:0] pool_max,
  output logic [1:0]        frame_cnt,
  output logic              drop_err
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] slot [4];
  logic cap, drop;
  // A word is taken while collecting, or in FULL only when the drain frees the buffer on the same edge
  assign cap  = !clr && sa_en_result && (state == COLLECT || out_ready);
  assign drop = !clr && sa_en_result && state == FULL && !out_ready;
  assign out_valid = state == FULL;
  assign r_1_1 = slot[0];
  assign r_1_2 = slot[1];
  assign r_2_1 = slot[2];
  assign r_2_2 = slot[3];
  // Next state: clr aborts to COLLECT, drain leaves FULL, fourth capture enters FULL
  always_comb begin
    state_n = state;
    state_n = clr ? COLLECT
            : state == FULL ? (out_ready ? COLLECT : FULL)
            : (cap && frame_cnt == 2'd3) ? FULL : COLLECT;
  end
  // State register
  always_ff @(posedge clk) begin
    state <= reset ? COLLECT : state_n;
  end
  // Slot capture, running max and sticky overflow flag; frame_cnt is 0 in FULL so a drain-capture lands in r_1_1
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '{default: '0};
      pool_max  <= '0;
      frame_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (clr) frame_cnt <= '0;
      else if (cap) begin
        slot[frame_cnt] <= sa_result;
        frame_cnt       <= frame_cnt + 2'd1;
        pool_max        <= (frame_cnt == 2'd0 || sa_result > pool_max) ? sa_result : pool_max;
      end
      if (drop) drop_err <= 1'b1;
    end
  end
endmodule

// File: doc/sa_result_pool.md
Name: sa_result_pool

Overview:
- Downstream consumer of the systolic-array convolution stage.
- Captures the serial result stream (one 8-bit value per sa_en_result strobe) into a 2x2 output-feature buffer in raster order.
- Tracks the 2x2 max-pool value alongside the buffer.
- Presents the completed frame with a valid/ready handshake to the next stage (display/result register bank).

Parameters:
- DATA_W, 8, width of each result word and of the pooled maximum.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous abort: discards a partial frame, leaves drop_err unchanged.
- sa_en_result  input  1  one-cycle strobe; sa_result is valid this cycle.
- sa_result  input  DATA_W  convolution result word, unsigned.
- out_ready  input  1  downstream accepts the frame when high together with out_valid.
- out_valid  output  1  complete 2x2 frame available.
- r_1_1, r_1_2, r_2_1, r_2_2  output  DATA_W each  buffered results (row_col).
- pool_max  output  DATA_W  unsigned maximum of the four buffered results.
- frame_cnt  output  2  number of results captured in the current frame (0-3).
- drop_err  output  1  sticky: a strobe arrived while the buffer was full and no slot was freed.

Behaviour:
- Reset (reset=1 at clk edge):
  - All r_*, pool_max, frame_cnt and out_valid are set to 0.
  - drop_err is cleared.
  - State goes to COLLECT.
  - reset has priority over clr, strobes and handshake.
- States: COLLECT, FULL.
- COLLECT:
  - On each sa_en_result, sa_result is written to the slot indexed by frame_cnt: 0→r_1_1, 1→r_1_2, 2→r_2_1, 3→r_2_2.
  - On the same edge, frame_cnt increments.
  - Running max: the first result of a frame loads pool_max directly. Later results update pool_max = max(pool_max, sa_result), unsigned compare.
  - On the 4th strobe (frame_cnt=3), frame_cnt wraps to 0 and the state moves to FULL.
  - out_valid goes high the cycle after the 4th strobe (latency 1).
- FULL:
  - out_valid=1; r_* and pool_max are held stable.
  - If out_ready=1, the frame is consumed at that edge and the state returns to COLLECT; out_valid drops the next cycle.
  - If out_ready=1 and sa_en_result=1 on the same edge, the drain completes and the incoming word is captured as r_1_1 of the new frame: frame_cnt=1, pool_max=sa_result. No data loss.
  - If out_ready=0 and sa_en_result=1, the word is discarded and drop_err sets to 1, staying set until reset. Buffer contents are unchanged.
- clr:
  - In COLLECT, frame_cnt returns to 0 and any strobe on the same edge is ignored. r_* values are not cleared.
  - In FULL, clr discards the frame: out_valid drops and the state returns to COLLECT.
- Strobes with a gap of any length between them are legal. Back-to-back strobes on consecutive cycles must be accepted without loss.
- frame_cnt is not incremented by strobes while in FULL.

Test Plan:
- Reset, then 4 back-to-back strobes of 10, 200, 7, 55 with out_ready=0:
  - out_valid rises exactly 1 cycle after the 4th strobe.
  - r_1_1=10, r_1_2=200, r_2_1=7, r_2_2=55, pool_max=200, drop_err=0.
- In FULL with out_ready held 0, strobe value 99:
  - drop_err=1 and remains 1.
  - Buffer unchanged, pool_max=200.
  - After out_ready=1 for one cycle, out_valid=0 next cycle and drop_err is still 1.
- FULL frame with out_ready=1 and strobe value 33 on the same edge:
  - Frame consumed; next cycle out_valid=0, frame_cnt=1, r_1_1=33, pool_max=33, drop_err unchanged.
- Strobes 0, 0, 255, 1 spaced 3 idle cycles apart:
  - out_valid only after the 4th strobe; pool_max=255, confirming unsigned compare.
- Two strobes (5, 6), then clr=1 with a simultaneous strobe of 8, then strobes 1, 2, 3, 4:
  - The clr-cycle strobe is ignored.
  - Final frame is r_1_1=1, r_1_2=2, r_2_1=3, r_2_2=4, pool_max=4.
- Assert reset while in FULL with drop_err=1:
  - Next cycle all outputs are 0 and state is COLLECT.
  - A subsequent 4-strobe frame completes normally.
